// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared definitions for the HD44780-style LCD bus (driver and receiver).
// Contents: instruction opcode masks/values, DDRAM line-2 base address, the blank
// character, the receiver FSM state type and a wrapping address-counter helper.
// Build option used by the receiver: LCD_BUSY_READ_EN (busy-flag / data read-back).
package lcd_pkg;

    // Opcodes are identified by their leading 1; mask selects the fixed bits.
    localparam logic [7:0] OP_CLR_MASK   = 8'hFF;
    localparam logic [7:0] OP_CLR        = 8'h01;
    localparam logic [7:0] OP_HOME_MASK  = 8'hFE;
    localparam logic [7:0] OP_HOME       = 8'h02;
    localparam logic [7:0] OP_ENTRY_MASK = 8'hFC;
    localparam logic [7:0] OP_ENTRY      = 8'h04;
    localparam logic [7:0] OP_ONOFF_MASK = 8'hF8;
    localparam logic [7:0] OP_ONOFF      = 8'h08;
    localparam logic [7:0] OP_SHIFT_MASK = 8'hF0;
    localparam logic [7:0] OP_SHIFT      = 8'h10;
    localparam logic [7:0] OP_FUNC_MASK  = 8'hE0;
    localparam logic [7:0] OP_FUNC       = 8'h20;
    localparam logic [7:0] OP_CGRAM_MASK = 8'hC0;
    localparam logic [7:0] OP_CGRAM      = 8'h40;
    localparam logic [7:0] OP_DDRAM_MASK = 8'h80;
    localparam logic [7:0] OP_DDRAM      = 8'h80;

    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [7:0] SPACE_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CLEAR = 2'd2,
        BUSY  = 2'd3
    } lcd_state_e;

    // Step the linear DDRAM index up or down, wrapping at both ends.
    function automatic logic [4:0] idx_step(input logic [4:0] idx, input logic up,
                                            input logic [4:0] last);
        logic [4:0] r;
        if (up) r = (idx == last) ? 5'd0 : idx + 5'd1;
        else    r = (idx == 5'd0) ? last : idx - 5'd1;
        return r;
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync -- brings the asynchronous LCD bus {e, rs, rw, data} into clk with a
// 2-FF synchronizer and flags the falling edge of e.
// Ports: clk, rst_n (async, active-low); e_i/rs_i/rw_i/data_i raw bus;
// e_o/rs_o/rw_o synchronized levels; fall_o one-cycle pulse on e falling, with
// fall_rs_o/fall_rw_o/fall_data_o holding the fields as they were while e was high.
module lcd_bus_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [7:0] data_i,
    output logic       e_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic       fall_o,
    output logic       fall_rs_o,
    output logic       fall_rw_o,
    output logic [7:0] fall_data_o
);
    // Bit layout: [10]=e [9]=rs [8]=rw [7:0]=data
    logic [10:0] s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {e_i, rs_i, rw_i, data_i};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign e_o  = s2_q[10];
    assign rs_o = s2_q[9];
    assign rw_o = s2_q[8];

    // s3 still holds the last sample taken with e high, so the fields it carries
    // are the ones the driver set up for this strobe.
    assign fall_o      = s3_q[10] & ~s2_q[10];
    assign fall_rs_o   = s3_q[9];
    assign fall_rw_o   = s3_q[8];
    assign fall_data_o = s3_q[7:0];

endmodule

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver -- HD44780-style character LCD model with a 2xLINE_LEN DDRAM shadow.
// Ports: clk; rst (async, active-low); lcd_rs/lcd_rw/lcd_e/lcd_data bus from the driver;
// lcd_dout/lcd_doe read-back; rd_index/rd_char shadow read port (1-cycle latency);
// cursor_idx, disp_on, busy status; wr_strobe / cmd_err single-cycle pulses.
// Build option: define LCD_BUSY_READ_EN to enable busy-flag and DDRAM read-back on rw=1.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int LINE_LEN = 16,
    parameter int BUSY_CYC = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_dout,
    output logic       lcd_doe,
    input  logic [4:0] rd_index,
    output logic [7:0] rd_char,
    output logic [4:0] cursor_idx,
    output logic       disp_on,
    output logic       busy,
    output logic       wr_strobe,
    output logic       cmd_err
);
    localparam int         DEPTH     = 2 * LINE_LEN;
    localparam int         CLR_EXTRA = (BUSY_CYC > DEPTH) ? BUSY_CYC - DEPTH : 0;
    localparam logic [4:0] LAST_IDX  = 5'(DEPTH - 1);
    localparam logic [5:0] DEPTH6    = 6'(DEPTH);
    localparam logic [6:0] LINE_LEN7 = 7'(LINE_LEN);

    logic       e_s, rs_s, rw_s;
    logic       fall, fall_rs, fall_rw;
    logic [7:0] fall_data;

    lcd_bus_sync u_sync (
        .clk         (clk),
        .rst_n       (rst),
        .e_i         (lcd_e),
        .rs_i        (lcd_rs),
        .rw_i        (lcd_rw),
        .data_i      (lcd_data),
        .e_o         (e_s),
        .rs_o        (rs_s),
        .rw_o        (rw_s),
        .fall_o      (fall),
        .fall_rs_o   (fall_rs),
        .fall_rw_o   (fall_rw),
        .fall_data_o (fall_data)
    );

    lcd_state_e  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [4:0]  clr_q, clr_d;
    logic [4:0]  idx_q, idx_d;
    logic        inc_q, inc_d;
    logic        disp_on_q, disp_on_d;
    logic        txn_rs_q, txn_rs_d;
    logic [7:0]  txn_data_q, txn_data_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        cmd_err_q, cmd_err_d;
    logic [7:0]  rd_char_q;

    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_q [DEPTH];
    logic [6:0]  line2_off;

    assign line2_off = txn_data_q[6:0] - LINE2_BASE;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        clr_d       = clr_q;
        idx_d       = idx_q;
        inc_d       = inc_q;
        disp_on_d   = disp_on_q;
        txn_rs_d    = txn_rs_q;
        txn_data_d  = txn_data_q;
        wr_strobe_d = 1'b0;
        cmd_err_d   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = idx_q;
        mem_wdata   = txn_data_q;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!fall_rw) begin
                        txn_rs_d   = fall_rs;
                        txn_data_d = fall_data;
                        state_d    = EXEC;
                    end
`ifdef LCD_BUSY_READ_EN
                    else if (fall_rs) begin
                        // Data read completes on the falling strobe: advance like a write.
                        idx_d = idx_step(idx_q, inc_q, LAST_IDX);
                    end
`endif
                end
            end
            EXEC: begin
                state_d = BUSY;
                timer_d = 16'(BUSY_CYC - 1);
                if (txn_rs_q) begin
                    mem_we      = 1'b1;
                    wr_strobe_d = 1'b1;
                    idx_d       = idx_step(idx_q, inc_q, LAST_IDX);
                end else if ((txn_data_q & OP_DDRAM_MASK) == OP_DDRAM) begin
                    if (txn_data_q[6:0] < LINE_LEN7)
                        idx_d = txn_data_q[4:0];
                    else if (txn_data_q[6:0] >= LINE2_BASE && line2_off < LINE_LEN7)
                        idx_d = 5'(LINE_LEN) + line2_off[4:0];
                    else
                        cmd_err_d = 1'b1;
                end else if ((txn_data_q & OP_CGRAM_MASK) == OP_CGRAM) begin
                    cmd_err_d = 1'b1;
                end else if ((txn_data_q & OP_FUNC_MASK) == OP_FUNC) begin
                    // Function set: accepted, bus width/font are not modelled.
                end else if ((txn_data_q & OP_SHIFT_MASK) == OP_SHIFT) begin
                    if (!txn_data_q[3])
                        idx_d = idx_step(idx_q, txn_data_q[2], LAST_IDX);
                end else if ((txn_data_q & OP_ONOFF_MASK) == OP_ONOFF) begin
                    disp_on_d = txn_data_q[2];
                end else if ((txn_data_q & OP_ENTRY_MASK) == OP_ENTRY) begin
                    inc_d = txn_data_q[1];
                end else if ((txn_data_q & OP_HOME_MASK) == OP_HOME) begin
                    idx_d = 5'd0;
                end else if ((txn_data_q & OP_CLR_MASK) == OP_CLR) begin
                    idx_d   = 5'd0;
                    inc_d   = 1'b1;
                    clr_d   = 5'd0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                mem_wdata = SPACE_CHAR;
                clr_d     = clr_q + 5'd1;
                if (clr_q == LAST_IDX) begin
                    // Whatever part of the busy time the blanking sweep did not cover.
                    if (CLR_EXTRA > 0) begin
                        state_d = BUSY;
                        timer_d = 16'(CLR_EXTRA - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BUSY: begin
                if (timer_q == 16'd0) state_d = IDLE;
                else                  timer_d = timer_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase

        // Strobes arriving while busy are dropped without touching the timer.
        if (fall && state_q != IDLE) begin
            if (!fall_rw) cmd_err_d = 1'b1;
`ifdef LCD_BUSY_READ_EN
            else if (fall_rs) cmd_err_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            clr_q       <= '0;
            idx_q       <= '0;
            inc_q       <= 1'b1;
            disp_on_q   <= 1'b0;
            txn_rs_q    <= 1'b0;
            txn_data_q  <= '0;
            wr_strobe_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            clr_q       <= clr_d;
            idx_q       <= idx_d;
            inc_q       <= inc_d;
            disp_on_q   <= disp_on_d;
            txn_rs_q    <= txn_rs_d;
            txn_data_q  <= txn_data_d;
            wr_strobe_q <= wr_strobe_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // DDRAM shadow: one register per cell so reset can blank the whole display.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ddram
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    mem_q[gi] <= SPACE_CHAR;
                else if (mem_we && mem_waddr == 5'(gi))
                    mem_q[gi] <= mem_wdata;
            end
        end
    endgenerate

    // Registered read sees the pre-write contents on a same-cycle collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_char_q <= SPACE_CHAR;
        else if ({1'b0, rd_index} < DEPTH6)
            rd_char_q <= mem_q[rd_index];
        else
            rd_char_q <= SPACE_CHAR;
    end

    assign rd_char    = rd_char_q;
    assign cursor_idx = idx_q;
    assign disp_on    = disp_on_q;
    assign busy       = (state_q != IDLE);
    assign wr_strobe  = wr_strobe_q;
    assign cmd_err    = cmd_err_q;

`ifdef LCD_BUSY_READ_EN
    // Address form of the index: line 2 starts at 0x40.
    assign lcd_doe  = e_s & rw_s;
    assign lcd_dout = !lcd_doe ? 8'h00 :
                      rs_s     ? mem_q[idx_q] :
                                 {busy, idx_q[4], 2'b00, idx_q[3:0]};
`else
    logic unused_sync;
    assign unused_sync = &{1'b0, e_s, rs_s, rw_s};
    assign lcd_doe  = 1'b0;
    assign lcd_dout = 8'h00;
`endif

endmodule
